tl45_rfetch: RTL and testbench
==============================

TL45_RFETCH -- requirements
Module: tl45_rfetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and operand width.
REQ-002 SHALL have parameter OP_LW, default 5'h14, meaning the opcode that triggers the load-use interlock.
REQ-003 SHALL have ports i_clk (input, 1, clock) and i_reset_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have i_pipe_stall (input, 1, downstream stall) and i_pipe_flush (input, 1, downstream flush).
REQ-005 SHALL have o_pipe_stall (output, 1, stall to decode) and o_pipe_flush (output, 1, flush to decode).
REQ-006 SHALL have decode inputs: i_opcode (5), i_dr (4), i_sr1 (4), i_sr2 (4), i_imm_sel (1, sr2 replaced by immediate), i_imm (DATA_W), i_jmp_cond (4), i_target_offset (DATA_W), i_pc (DATA_W).
REQ-007 SHALL have ALU forward inputs i_of_reg (4) and i_of_val (DATA_W); register 0 means no forward.
REQ-008 SHALL have MEM forward inputs i_mem_reg (4) and i_mem_val (DATA_W); register 0 means no forward.
REQ-009 SHALL have writeback inputs i_wb_reg (4) and i_wb_val (DATA_W); register 0 means no write.
REQ-010 SHALL have registered outputs o_opcode (5), o_dr (4), o_jmp_cond (4), o_sr1_val (DATA_W), o_sr2_val (DATA_W), o_target_offset (DATA_W), o_pc (DATA_W).

Function
REQ-011 SHALL hold a 16 x DATA_W register file; r0 SHALL read 0 and SHALL ignore writes.
REQ-012 SHALL write i_wb_val to i_wb_reg on every rising edge when i_wb_reg != 0, regardless of stall or flush.
REQ-013 SHALL resolve each source with priority: r0 -> 0, then ALU forward, then MEM forward, then WB, then register file.
REQ-014 SHALL take sr2 from i_imm when i_imm_sel=1 and SHALL then ignore i_sr2 for hazard detection.
REQ-015 SHALL define the load-use hazard as state RUN, o_opcode==OP_LW, o_dr!=0, and o_dr matching i_sr1 or a used i_sr2.
REQ-016 SHALL implement FSM states RUN and BUBBLE, each with a 1-cycle latency from input to output buffer.
REQ-017 RUN transition: on a hazard with i_pipe_stall=0, SHALL load a zero bubble (opcode 0, dr 0, all values 0), assert o_pipe_stall, and go to BUBBLE.
REQ-018 BUBBLE transition: SHALL go to RUN unconditionally and SHALL capture the held decode inputs, with the load result arriving via the MEM forward.
REQ-019 SHALL hold the output buffer and FSM state unchanged while i_pipe_stall=1, even during a hazard.
REQ-020 SHALL drive o_pipe_stall = i_pipe_stall OR (hazard AND state RUN).
REQ-021 SHALL drive o_pipe_flush = i_pipe_flush, combinationally.
REQ-022 i_pipe_flush=1 SHALL clear the output buffer to zero and force RUN; it overrides stall and hazard, and register-file writes still occur.
REQ-023 SHALL load the buffer from decode inputs and resolved operands in RUN when there is no stall, flush or hazard.

Reset
REQ-024 While i_reset_n=0, SHALL asynchronously clear all output-buffer registers and all 16 register-file entries to 0, and set the state to RUN.
REQ-025 Reset asserted mid-bubble SHALL abandon the bubble, with no residual stall after release.
REQ-026 SHALL resume normal operation on the first rising i_clk after i_reset_n deasserts.

Structure
REQ-027 SHALL take opcode constants (OP_LW, NOP=0) and the FSM state enum from shared package tl45_pkg.
REQ-028 SHALL contain one sub-module, tl45_regfile (2 async read ports, 1 write port, r0 hardwired), with forwarding and FSM in tl45_rfetch.

Verification
REQ-029 Write r3=0x1234 via WB, then issue ADD r1,r3,r3 -> next cycle o_sr1_val=o_sr2_val=0x1234.
REQ-030 Set i_of_reg=5, i_of_val=0xAAAA, i_mem_reg=5, i_mem_val=0xBBBB, RF r5=0xCCCC, and read r5 -> o_sr1_val=0xAAAA.
REQ-031 Issue LW r2 then ADD r4,r2,r1 -> one cycle with o_pipe_stall=1 and output opcode 0; next cycle ADD is emitted with o_sr1_val = i_mem_val.
REQ-032 Raise i_pipe_stall for 3 cycles during a hazard -> outputs held, no bubble inserted, bubble inserted after release.
REQ-033 Assert i_pipe_flush in BUBBLE with i_wb_reg=7, i_wb_val=0x55 -> outputs 0, state RUN, r7 later reads 0x55.
REQ-034 Write r0=0xFFFF via WB and read r0, including with i_of_reg=0 -> value 0.

Source files
------------

// File: rtl/tl45_pkg.sv
// tl45_pkg: opcode constants and fetch-stage FSM states shared by the tl45 operand-fetch slice.
package tl45_pkg;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LW  = 5'h14;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } state_e;

endpackage

// File: rtl/tl45_regfile.sv
// tl45_regfile: 16-entry register file, two async read ports, one write port, r0 hardwired to zero.
module tl45_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [3:0]        i_ra,
    input  logic [3:0]        i_rb,
    output logic [DATA_W-1:0] o_ra_val,
    output logic [DATA_W-1:0] o_rb_val,
    input  logic [3:0]        i_wr_reg,
    input  logic [DATA_W-1:0] i_wr_val
);

    logic [DATA_W-1:0] mem_q [16];
    logic [DATA_W-1:0] mem_d [16];

    always_comb begin
        mem_d = mem_q;
        if (i_wr_reg != 4'd0) mem_d[i_wr_reg] = i_wr_val;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) mem_q <= '{default: '0};
        else            mem_q <= mem_d;
    end

    assign o_ra_val = (i_ra == 4'd0) ? '0 : mem_q[i_ra];
    assign o_rb_val = (i_rb == 4'd0) ? '0 : mem_q[i_rb];

endmodule

// File: rtl/tl45_rfetch.sv
// tl45_rfetch: operand fetch stage with ALU/MEM/WB forwarding and a one-bubble load-use interlock.
module tl45_rfetch #(
    parameter int         DATA_W = 32,
    parameter logic [4:0] OP_LW  = tl45_pkg::OP_LW
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_pipe_stall,
    input  logic              i_pipe_flush,
    output logic              o_pipe_stall,
    output logic              o_pipe_flush,
    input  logic [4:0]        i_opcode,
    input  logic [3:0]        i_dr,
    input  logic [3:0]        i_sr1,
    input  logic [3:0]        i_sr2,
    input  logic              i_imm_sel,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [3:0]        i_jmp_cond,
    input  logic [DATA_W-1:0] i_target_offset,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [3:0]        i_of_reg,
    input  logic [DATA_W-1:0] i_of_val,
    input  logic [3:0]        i_mem_reg,
    input  logic [DATA_W-1:0] i_mem_val,
    input  logic [3:0]        i_wb_reg,
    input  logic [DATA_W-1:0] i_wb_val,
    output logic [4:0]        o_opcode,
    output logic [3:0]        o_dr,
    output logic [3:0]        o_jmp_cond,
    output logic [DATA_W-1:0] o_sr1_val,
    output logic [DATA_W-1:0] o_sr2_val,
    output logic [DATA_W-1:0] o_target_offset,
    output logic [DATA_W-1:0] o_pc
);

    import tl45_pkg::*;

    state_e            state_q, state_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [3:0]        dr_q, dr_d, jmp_cond_q, jmp_cond_d;
    logic [DATA_W-1:0] sr1_val_q, sr1_val_d, sr2_val_q, sr2_val_d;
    logic [DATA_W-1:0] target_offset_q, target_offset_d, pc_q, pc_d;
    logic [DATA_W-1:0] rf_a, rf_b, sr1_res, sr2_res;
    logic              hazard, clr, ld;

    tl45_regfile #(.DATA_W(DATA_W)) u_regfile (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ra      (i_sr1),
        .i_rb      (i_sr2),
        .o_ra_val  (rf_a),
        .o_rb_val  (rf_b),
        .i_wr_reg  (i_wb_reg),
        .i_wr_val  (i_wb_val)
    );

    always_comb begin
        sr1_res = (i_sr1 == 4'd0)      ? '0 :
                  (i_sr1 == i_of_reg)  ? i_of_val :
                  (i_sr1 == i_mem_reg) ? i_mem_val :
                  (i_sr1 == i_wb_reg)  ? i_wb_val : rf_a;
        sr2_res = i_imm_sel            ? i_imm :
                  (i_sr2 == 4'd0)      ? '0 :
                  (i_sr2 == i_of_reg)  ? i_of_val :
                  (i_sr2 == i_mem_reg) ? i_mem_val :
                  (i_sr2 == i_wb_reg)  ? i_wb_val : rf_b;
        // The loaded value is not yet available; sr2 only counts when it is actually read.
        hazard = (state_q == ST_RUN) && (opcode_q == OP_LW) && (dr_q != 4'd0) &&
                 ((dr_q == i_sr1) || (!i_imm_sel && dr_q == i_sr2));
        clr = i_pipe_flush || (!i_pipe_stall && hazard);
        ld  = !i_pipe_flush && !i_pipe_stall && !hazard;
        state_d         = i_pipe_flush ? ST_RUN : i_pipe_stall ? state_q : hazard ? ST_BUBBLE : ST_RUN;
        opcode_d        = clr ? OP_NOP : ld ? i_opcode        : opcode_q;
        dr_d            = clr ? '0     : ld ? i_dr            : dr_q;
        jmp_cond_d      = clr ? '0     : ld ? i_jmp_cond      : jmp_cond_q;
        sr1_val_d       = clr ? '0     : ld ? sr1_res         : sr1_val_q;
        sr2_val_d       = clr ? '0     : ld ? sr2_res         : sr2_val_q;
        target_offset_d = clr ? '0     : ld ? i_target_offset : target_offset_q;
        pc_d            = clr ? '0     : ld ? i_pc            : pc_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q         <= ST_RUN;
            opcode_q        <= OP_NOP;
            dr_q            <= '0;
            jmp_cond_q      <= '0;
            sr1_val_q       <= '0;
            sr2_val_q       <= '0;
            target_offset_q <= '0;
            pc_q            <= '0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            dr_q            <= dr_d;
            jmp_cond_q      <= jmp_cond_d;
            sr1_val_q       <= sr1_val_d;
            sr2_val_q       <= sr2_val_d;
            target_offset_q <= target_offset_d;
            pc_q            <= pc_d;
        end
    end

    assign o_pipe_stall    = i_pipe_stall || hazard;
    assign o_pipe_flush    = i_pipe_flush;
    assign o_opcode        = opcode_q;
    assign o_dr            = dr_q;
    assign o_jmp_cond      = jmp_cond_q;
    assign o_sr1_val       = sr1_val_q;
    assign o_sr2_val       = sr2_val_q;
    assign o_target_offset = target_offset_q;
    assign o_pc            = pc_q;

endmodule

// File: tb/tb_tl45_rfetch.sv
// tb_tl45_rfetch: vector table, hand-written interlock/flush/reset sequences and a randomized model check.
module tb_tl45_rfetch;

    localparam logic [4:0] LW = 5'h14;

    logic        i_clk, i_reset_n, i_pipe_stall, i_pipe_flush, o_pipe_stall, o_pipe_flush;
    logic [4:0]  i_opcode, o_opcode;
    logic [3:0]  i_dr, i_sr1, i_sr2, i_jmp_cond, i_of_reg, i_mem_reg, i_wb_reg, o_dr, o_jmp_cond;
    logic        i_imm_sel;
    logic [31:0] i_imm, i_target_offset, i_pc, i_of_val, i_mem_val, i_wb_val;
    logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

    tl45_rfetch #(.DATA_W(32), .OP_LW(LW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
        .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
        .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
        .i_imm_sel(i_imm_sel), .i_imm(i_imm), .i_jmp_cond(i_jmp_cond),
        .i_target_offset(i_target_offset), .i_pc(i_pc),
        .i_of_reg(i_of_reg), .i_of_val(i_of_val),
        .i_mem_reg(i_mem_reg), .i_mem_val(i_mem_val),
        .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
        .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
        .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
        .o_target_offset(o_target_offset), .o_pc(o_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle;
        i_pipe_stall = 0; i_pipe_flush = 0;
        i_opcode = 0; i_dr = 0; i_sr1 = 0; i_sr2 = 0; i_imm_sel = 0; i_imm = 0;
        i_jmp_cond = 0; i_target_offset = 0; i_pc = 0;
        i_of_reg = 0; i_of_val = 0; i_mem_reg = 0; i_mem_val = 0; i_wb_reg = 0; i_wb_val = 0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [3:0] dr, input logic [3:0] s1,
                         input logic [3:0] s2, input logic isel, input logic [31:0] imm);
        i_opcode = op; i_dr = dr; i_sr1 = s1; i_sr2 = s2; i_imm_sel = isel; i_imm = imm;
    endtask

    typedef struct {
        logic [3:0]  wb_reg;  logic [31:0] wb_val;
        logic [3:0]  of_reg;  logic [31:0] of_val;
        logic [3:0]  mem_reg; logic [31:0] mem_val;
        logic [4:0]  op;      logic [3:0]  dr;
        logic [3:0]  sr1;     logic [3:0]  sr2;
        logic        isel;    logic [31:0] imm;
        logic [31:0] e1;      logic [31:0] e2;
    } vec_t;

    vec_t tbl[11];

    // Behavioural reference state for the random phase.
    logic [31:0] mrf [16];
    logic [4:0]  mop;
    logic [3:0]  mdr, mjc;
    logic [31:0] ms1, ms2, mto, mpc;
    bit          mbub;

    function automatic logic [31:0] src(input logic [3:0] r);
        if (r == 0)         return 32'h0;
        if (r == i_of_reg)  return i_of_val;
        if (r == i_mem_reg) return i_mem_val;
        if (r == i_wb_reg)  return i_wb_val;
        return mrf[r];
    endfunction

    function automatic logic [3:0] rreg;
        return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
    endfunction

    initial begin
        bit hz;
        logic [31:0] s1, s2;
        tbl[0]  = '{4'd3, 32'h1234, 4'd0, 32'h0,    4'd0, 32'h0,    5'h01, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0,  32'h0,    32'h0};
        tbl[1]  = '{4'd0, 32'h0,    4'd0, 32'h0,    4'd0, 32'h0,    5'h01, 4'd1, 4'd3, 4'd3, 1'b0, 32'h0,  32'h1234, 32'h1234};
        tbl[2]  = '{4'd5, 32'hCCCC, 4'd0, 32'h0,    4'd0, 32'h0,    5'h02, 4'd6, 4'd3, 4'd0, 1'b0, 32'h0,  32'h1234, 32'h0};
        tbl[3]  = '{4'd0, 32'h0,    4'd5, 32'hAAAA, 4'd5, 32'hBBBB, 5'h01, 4'd1, 4'd5, 4'd5, 1'b0, 32'h0,  32'hAAAA, 32'hAAAA};
        tbl[4]  = '{4'd5, 32'hDDDD, 4'd0, 32'h0,    4'd5, 32'hBBBB, 5'h01, 4'd1, 4'd5, 4'd3, 1'b0, 32'h0,  32'hBBBB, 32'h1234};
        tbl[5]  = '{4'd0, 32'h0,    4'd0, 32'h0,    4'd0, 32'h0,    5'h01, 4'd1, 4'd5, 4'd5, 1'b0, 32'h0,  32'hDDDD, 32'hDDDD};
        tbl[6]  = '{4'd0, 32'hFFFF, 4'd0, 32'h0,    4'd0, 32'h0,    5'h03, 4'd2, 4'd0, 4'd0, 1'b0, 32'h0,  32'h0,    32'h0};
        tbl[7]  = '{4'd0, 32'h0,    4'd0, 32'h9999, 4'd0, 32'h8888, 5'h03, 4'd2, 4'd0, 4'd0, 1'b0, 32'h0,  32'h0,    32'h0};
        tbl[8]  = '{4'd0, 32'h0,    4'd0, 32'h0,    4'd0, 32'h0,    5'h03, 4'd2, 4'd0, 4'd0, 1'b0, 32'h0,  32'h0,    32'h0};
        tbl[9]  = '{4'd0, 32'h0,    4'd0, 32'h0,    4'd0, 32'h0,    5'h04, 4'd2, 4'd5, 4'd5, 1'b1, 32'h77, 32'hDDDD, 32'h77};
        tbl[10] = '{4'd0, 32'h0,    4'd3, 32'h1111, 4'd0, 32'h0,    5'h04, 4'd2, 4'd3, 4'd0, 1'b0, 32'h0,  32'h1111, 32'h0};

        idle();
        i_reset_n = 0;
        tick();
        tick();
        chk("rst_opcode", {27'h0, o_opcode}, 32'h0);
        chk("rst_sr1", o_sr1_val, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_stall", {31'h0, o_pipe_stall}, 32'h0);
        i_reset_n = 1;

        for (int i = 0; i < 11; i++) begin
            i_wb_reg = tbl[i].wb_reg; i_wb_val = tbl[i].wb_val;
            i_of_reg = tbl[i].of_reg; i_of_val = tbl[i].of_val;
            i_mem_reg = tbl[i].mem_reg; i_mem_val = tbl[i].mem_val;
            issue(tbl[i].op, tbl[i].dr, tbl[i].sr1, tbl[i].sr2, tbl[i].isel, tbl[i].imm);
            tick();
            chk($sformatf("vec%0d_sr1", i), o_sr1_val, tbl[i].e1);
            chk($sformatf("vec%0d_sr2", i), o_sr2_val, tbl[i].e2);
            chk($sformatf("vec%0d_op", i), {27'h0, o_opcode}, {27'h0, tbl[i].op});
            chk($sformatf("vec%0d_dr", i), {28'h0, o_dr}, {28'h0, tbl[i].dr});
        end
        idle();

        // Load-use interlock: LW r2 then ADD r4,r2,r1.
        issue(LW, 4'd2, 4'd1, 4'd0, 1'b1, 32'h8);
        tick();
        chk("lu_lw_op", {27'h0, o_opcode}, {27'h0, LW});
        issue(5'h01, 4'd4, 4'd2, 4'd1, 1'b0, 32'h0);
        #1 chk("lu_stall", {31'h0, o_pipe_stall}, 32'h1);
        tick();
        chk("lu_bubble_op", {27'h0, o_opcode}, 32'h0);
        chk("lu_bubble_dr", {28'h0, o_dr}, 32'h0);
        chk("lu_bubble_nostall", {31'h0, o_pipe_stall}, 32'h0);
        i_mem_reg = 4'd2; i_mem_val = 32'h5A5A;
        tick();
        chk("lu_add_op", {27'h0, o_opcode}, 32'h1);
        chk("lu_add_sr1", o_sr1_val, 32'h5A5A);
        chk("lu_add_dr", {28'h0, o_dr}, 32'h4);
        idle();

        // Downstream stall held over a hazard.
        issue(LW, 4'd2, 4'd1, 4'd0, 1'b1, 32'h8);
        tick();
        issue(5'h01, 4'd4, 4'd2, 4'd1, 1'b0, 32'h0);
        i_pipe_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("st_stall", {31'h0, o_pipe_stall}, 32'h1);
            tick();
            chk("st_hold_op", {27'h0, o_opcode}, {27'h0, LW});
            chk("st_hold_dr", {28'h0, o_dr}, 32'h2);
        end
        i_pipe_stall = 0;
        #1 chk("st_hz_stall", {31'h0, o_pipe_stall}, 32'h1);
        tick();
        chk("st_bubble_op", {27'h0, o_opcode}, 32'h0);
        i_mem_reg = 4'd2; i_mem_val = 32'h600D;
        tick();
        chk("st_add_op", {27'h0, o_opcode}, 32'h1);
        chk("st_add_sr1", o_sr1_val, 32'h600D);
        idle();

        // Flush while in the bubble, with a concurrent write-back.
        issue(LW, 4'd2, 4'd1, 4'd0, 1'b1, 32'h8);
        i_pc = 32'h100;
        tick();
        issue(5'h01, 4'd4, 4'd2, 4'd1, 1'b0, 32'h0);
        tick();
        chk("fl_bubble_op", {27'h0, o_opcode}, 32'h0);
        i_pipe_flush = 1; i_wb_reg = 4'd7; i_wb_val = 32'h55;
        #1 chk("fl_flush_out", {31'h0, o_pipe_flush}, 32'h1);
        tick();
        chk("fl_op", {27'h0, o_opcode}, 32'h0);
        chk("fl_sr1", o_sr1_val, 32'h0);
        chk("fl_pc", o_pc, 32'h0);
        chk("fl_stall", {31'h0, o_pipe_stall}, 32'h0);
        idle();
        issue(5'h01, 4'd4, 4'd7, 4'd7, 1'b0, 32'h0);
        tick();
        chk("fl_r7_sr1", o_sr1_val, 32'h55);
        chk("fl_r7_sr2", o_sr2_val, 32'h55);
        idle();

        // Reset asserted in the middle of a bubble.
        issue(LW, 4'd2, 4'd1, 4'd0, 1'b1, 32'h8);
        tick();
        issue(5'h01, 4'd4, 4'd2, 4'd1, 1'b0, 32'h0);
        i_pc = 32'h44;
        tick();
        #2 i_reset_n = 0;
        #1 chk("ar_op", {27'h0, o_opcode}, 32'h0);
        chk("ar_pc", o_pc, 32'h0);
        chk("ar_stall", {31'h0, o_pipe_stall}, 32'h0);
        #2 i_reset_n = 1;
        idle();
        issue(5'h01, 4'd4, 4'd3, 4'd7, 1'b0, 32'h0);
        tick();
        chk("ar_op_after", {27'h0, o_opcode}, 32'h1);
        chk("ar_r3_cleared", o_sr1_val, 32'h0);
        chk("ar_r7_cleared", o_sr2_val, 32'h0);
        chk("ar_no_stall", {31'h0, o_pipe_stall}, 32'h0);
        idle();

        // Randomized run against the reference model.
        i_reset_n = 0;
        tick();
        i_reset_n = 1;
        for (int r = 0; r < 16; r++) mrf[r] = 32'h0;
        mop = 0; mdr = 0; mjc = 0; ms1 = 0; ms2 = 0; mto = 0; mpc = 0; mbub = 0;
        for (int n = 0; n < 400; n++) begin
            i_opcode = ($urandom_range(0, 2) == 0) ? LW : 5'($urandom_range(0, 31));
            i_dr = 4'($urandom_range(0, 3));
            i_sr1 = 4'($urandom_range(0, 3));
            i_sr2 = 4'($urandom_range(0, 3));
            i_imm_sel = ($urandom_range(0, 3) == 0);
            i_imm = $urandom; i_target_offset = $urandom; i_pc = $urandom;
            i_jmp_cond = 4'($urandom_range(0, 15));
            i_of_reg = rreg(); i_mem_reg = rreg(); i_wb_reg = rreg();
            i_of_val = $urandom; i_mem_val = $urandom; i_wb_val = $urandom;
            i_pipe_stall = ($urandom_range(0, 4) == 0);
            i_pipe_flush = ($urandom_range(0, 9) == 0);
            #1;
            hz = !mbub && mop == LW && mdr != 0 && (mdr == i_sr1 || (!i_imm_sel && mdr == i_sr2));
            chk("rnd_stall", {31'h0, o_pipe_stall}, {31'h0, i_pipe_stall | hz});
            chk("rnd_flush", {31'h0, o_pipe_flush}, {31'h0, i_pipe_flush});
            s1 = src(i_sr1);
            s2 = i_imm_sel ? i_imm : src(i_sr2);
            if (i_pipe_flush || (!i_pipe_stall && hz)) begin
                mop = 0; mdr = 0; mjc = 0; ms1 = 0; ms2 = 0; mto = 0; mpc = 0;
                mbub = !i_pipe_flush;
            end else if (!i_pipe_stall) begin
                mop = i_opcode; mdr = i_dr; mjc = i_jmp_cond; ms1 = s1; ms2 = s2;
                mto = i_target_offset; mpc = i_pc; mbub = 0;
            end
            if (i_wb_reg != 0) mrf[i_wb_reg] = i_wb_val;
            tick();
            chk("rnd_op", {27'h0, o_opcode}, {27'h0, mop});
            chk("rnd_dr", {28'h0, o_dr}, {28'h0, mdr});
            chk("rnd_jc", {28'h0, o_jmp_cond}, {28'h0, mjc});
            chk("rnd_sr1", o_sr1_val, ms1);
            chk("rnd_sr2", o_sr2_val, ms2);
            chk("rnd_to", o_target_offset, mto);
            chk("rnd_pc", o_pc, mpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
